// File: rtl/pred_table_arbiter_if.sv
// Request/response bundle between the requester streams and pred_table_arbiter.
// master = requester side, slave = arbiter side.
interface pred_table_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 3
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*IDX_W-1:0] req_idx;
  logic [NUM_REQ-1:0]       req_outcome;
  logic [NUM_REQ-1:0]       req_gnt;
  logic                     rsp_valid;
  logic [ID_W-1:0]          rsp_id;
  logic                     rsp_pred;
  logic                     rsp_match;

  modport master (
    output req_valid, req_idx, req_outcome,
    input  req_gnt, rsp_valid, rsp_id, rsp_pred, rsp_match
  );

  modport slave (
    input  req_valid, req_idx, req_outcome,
    output req_gnt, rsp_valid, rsp_id, rsp_pred, rsp_match
  );
endinterface

// File: rtl/pred_table_arbiter.sv
// Round-robin shared table of 2-bit saturating predictors, one transaction per 3 cycles.
// Optional match/total statistics are built when PRED_TABLE_STATS_EN is defined.
module pred_table_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 3,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  pred_table_arbiter_if.slave  bus,
  input  logic                 stat_clr,
  output logic [CNT_W-1:0]     total_cnt,
  output logic [CNT_W-1:0]     match_cnt,
  output logic                 busy
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int DEPTH = 2 ** IDX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    UPD  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;

  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      gnt_id;
  logic                 gnt_any;
  logic [ID_W:0]        scan_pos;
  logic [NUM_REQ-1:0]   gnt_onehot;

  logic [ID_W-1:0]      cur_id;
  logic [IDX_W-1:0]     cur_idx;
  logic                 cur_outcome;
  logic [1:0]           tbl [DEPTH];
  logic [1:0]           cnt_q;
  logic [1:0]           cnt_upd;

  logic                 rsp_valid_int;
  logic [ID_W-1:0]      rsp_id_q;
  logic                 rsp_pred_q;
  logic                 rsp_match_q;

  // First valid requester at or after rr_ptr; scan_pos is kept one bit wider so
  // the wrap also works when NUM_REQ is not a power of two.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_id   = '0;
    scan_pos = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_pos = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (scan_pos >= (ID_W+1)'(NUM_REQ)) begin
        scan_pos = scan_pos - (ID_W+1)'(NUM_REQ);
      end
      if (!gnt_any && bus.req_valid[scan_pos[ID_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_id  = scan_pos[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    gnt_onehot    = '0;
    rsp_valid_int = 1'b0;
    busy          = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (gnt_any) begin
          gnt_onehot[gnt_id] = 1'b1;
          state_nxt          = RD;
        end
      end
      RD: begin
        state_nxt = UPD;
      end
      UPD: begin
        rsp_valid_int = 1'b1;
        state_nxt     = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    cnt_upd = cnt_q;
    if (cur_outcome) begin
      if (cnt_q != 2'b11) cnt_upd = cnt_q + 2'd1;
    end else begin
      if (cnt_q != 2'b00) cnt_upd = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr      <= '0;
      cur_id      <= '0;
      cur_idx     <= '0;
      cur_outcome <= 1'b0;
      cnt_q       <= 2'b01;
      rsp_id_q    <= '0;
      rsp_pred_q  <= 1'b0;
      rsp_match_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tbl[i] <= 2'b01;
      end
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            cur_id      <= gnt_id;
            cur_idx     <= bus.req_idx[gnt_id*IDX_W +: IDX_W];
            cur_outcome <= bus.req_outcome[gnt_id];
            rr_ptr      <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
          end
        end
        RD: begin
          cnt_q       <= tbl[cur_idx];
          rsp_id_q    <= cur_id;
          rsp_pred_q  <= tbl[cur_idx][1];
          rsp_match_q <= tbl[cur_idx][1] ~^ cur_outcome;
        end
        UPD: begin
          tbl[cur_idx] <= cnt_upd;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.req_gnt   = gnt_onehot;
  assign bus.rsp_valid = rsp_valid_int;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_pred  = rsp_pred_q;
  assign bus.rsp_match = rsp_match_q;

`ifdef PRED_TABLE_STATS_EN
  logic [CNT_W-1:0] total_q;
  logic [CNT_W-1:0] match_q;

  // stat_clr takes priority over a coincident response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total_q <= '0;
      match_q <= '0;
    end else if (stat_clr) begin
      total_q <= '0;
      match_q <= '0;
    end else if (rsp_valid_int) begin
      total_q <= total_q + 1'b1;
      match_q <= match_q + CNT_W'(rsp_match_q);
    end
  end

  assign total_cnt = total_q;
  assign match_cnt = match_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign total_cnt       = '0;
  assign match_cnt       = '0;
`endif

endmodule

// File: tb/tb_pred_table_arbiter.sv
// Randomized bench for pred_table_arbiter against a transaction-level model,
// plus directed sequences for latency, saturation, grant order, reset abort and stat clear.
module tb_pred_table_arbiter;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 3;
  localparam int CNT_W   = 8;
  localparam int DEPTH   = 1 << IDX_W;
`ifdef PRED_TABLE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             stat_clr;
  logic [CNT_W-1:0] total_cnt;
  logic [CNT_W-1:0] match_cnt;
  logic             busy;

  pred_table_arbiter_if #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) bus ();

  pred_table_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .stat_clr  (stat_clr),
    .total_cnt (total_cnt),
    .match_cnt (match_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // requester-side stimulus state
  logic [NUM_REQ-1:0] v;
  logic [NUM_REQ-1:0] oc;
  logic [IDX_W-1:0]   ix [NUM_REQ];
  int                 mode;

  // transaction-level reference: phase 0 idle, 1 read, 2 update
  int m_tbl [DEPTH];
  int m_ptr, m_phase, m_id, m_idx, m_out;
  int m_rsp_id, m_rsp_pred, m_rsp_match;
  int m_total, m_match;
  int pred_log[$];
  int match_log[$];
  int id_log[$];

  task automatic drive();
    bus.req_valid   = v;
    bus.req_outcome = oc;
    for (int i = 0; i < NUM_REQ; i++) bus.req_idx[i*IDX_W +: IDX_W] = ix[i];
  endtask

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) m_tbl[i] = 1;
    m_ptr = 0; m_phase = 0; m_id = 0; m_idx = 0; m_out = 0;
    m_rsp_id = 0; m_rsp_pred = 0; m_rsp_match = 0;
    m_total = 0; m_match = 0;
    pred_log.delete(); match_log.delete(); id_log.delete();
  endtask

  task automatic cycle();
    int g;
    int ph;
    logic [NUM_REQ-1:0] exp_gnt;
    @(negedge clk);
    g = -1;
    if (m_phase == 0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int c;
        c = (m_ptr + k) % NUM_REQ;
        if (g < 0 && v[c]) g = c;
      end
    end
    exp_gnt = '0;
    if (g >= 0) exp_gnt[g] = 1'b1;
    check_eq("gnt", bus.req_gnt, exp_gnt);
    check_eq("busy", busy, m_phase != 0);
    check_eq("rsp_valid", bus.rsp_valid, m_phase == 2);
    check_eq("rsp_id", bus.rsp_id, m_rsp_id);
    check_eq("rsp_pred", bus.rsp_pred, m_rsp_pred);
    check_eq("rsp_match", bus.rsp_match, m_rsp_match);
    check_eq("total_cnt", total_cnt, m_total);
    check_eq("match_cnt", match_cnt, m_match);
    if (bus.rsp_valid) begin
      pred_log.push_back(int'(bus.rsp_pred));
      match_log.push_back(int'(bus.rsp_match));
      id_log.push_back(int'(bus.rsp_id));
    end
    ph = m_phase;
    case (m_phase)
      0: if (g >= 0) begin
        m_id = g; m_idx = int'(ix[g]); m_out = int'(oc[g]);
        m_ptr = (g + 1) % NUM_REQ;
        m_phase = 1;
      end
      1: begin
        m_rsp_id    = m_id;
        m_rsp_pred  = (m_tbl[m_idx] >= 2) ? 1 : 0;
        m_rsp_match = (m_rsp_pred == m_out) ? 1 : 0;
        m_phase = 2;
      end
      default: begin
        if (m_out != 0) m_tbl[m_idx] = (m_tbl[m_idx] == 3) ? 3 : m_tbl[m_idx] + 1;
        else            m_tbl[m_idx] = (m_tbl[m_idx] == 0) ? 0 : m_tbl[m_idx] - 1;
        m_phase = 0;
      end
    endcase
    if (STATS) begin
      if (stat_clr) begin
        m_total = 0; m_match = 0;
      end else if (ph == 2) begin
        m_total = (m_total + 1) % (1 << CNT_W);
        m_match = (m_match + m_rsp_match) % (1 << CNT_W);
      end
    end
    @(posedge clk);
    #1;
    if (g >= 0) begin
      case (mode)
        0: if ($urandom_range(0, 1) == 1) begin
             ix[g] = IDX_W'($urandom_range(0, DEPTH-1));
             oc[g] = 1'($urandom_range(0, 1));
           end else v[g] = 1'b0;
        2: begin
             ix[g] = IDX_W'($urandom_range(0, DEPTH-1));
             oc[g] = 1'($urandom_range(0, 1));
           end
        4: v[g] = 1'b0;
        default: ;
      endcase
    end
    if (mode == 0) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!v[i] && $urandom_range(0, 2) == 0) begin
          v[i]  = 1'b1;
          ix[i] = IDX_W'($urandom_range(0, DEPTH-1));
          oc[i] = 1'($urandom_range(0, 1));
        end
      end
    end
    stat_clr = (mode == 0) &&
               ((m_phase == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 15) == 0);
    drive();
  endtask

  task automatic run_until(input int n, input int budget, input string tag);
    int cyc;
    cyc = 0;
    while (pred_log.size() < n && cyc < budget) begin
      cycle();
      cyc++;
    end
    check_eq(tag, pred_log.size() >= n, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    v = '0; stat_clr = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_reset();
  endtask

  initial begin
    mode = 4; v = '0; oc = '0; stat_clr = 1'b0; reset = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) ix[i] = '0;
    drive();
    m_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check_eq("rst_gnt", bus.req_gnt, 0);
    check_eq("rst_rsp_valid", bus.rsp_valid, 0);
    check_eq("rst_rsp_id", bus.rsp_id, 0);
    check_eq("rst_rsp_pred", bus.rsp_pred, 0);
    check_eq("rst_rsp_match", bus.rsp_match, 0);
    check_eq("rst_total", total_cnt, 0);
    check_eq("rst_match", match_cnt, 0);
    check_eq("rst_busy", busy, 0);
    @(posedge clk);
    #1;

    // weak-not-taken entry driven up to saturation
    mode = 1; v[0] = 1'b1; ix[0] = 3'd2; oc[0] = 1'b1; drive();
    run_until(4, 40, "t1_done");
    v = '0; drive();
    check_eq("t1_pred0", pred_log[0], 0);
    check_eq("t1_match0", match_log[0], 0);
    check_eq("t2_pred1", pred_log[1], 1);
    check_eq("t2_pred2", pred_log[2], 1);
    check_eq("t2_pred3", pred_log[3], 1);
    check_eq("t2_match3", match_log[3], 1);
    cycle();
    check_eq("t2_match_cnt", match_cnt, STATS ? 3 : 0);
    check_eq("t2_total_cnt", total_cnt, STATS ? 4 : 0);

    // all requesters continuously valid
    do_reset();
    mode = 2; v = '1;
    for (int i = 0; i < NUM_REQ; i++) begin
      ix[i] = IDX_W'($urandom_range(0, DEPTH-1));
      oc[i] = 1'($urandom_range(0, 1));
    end
    drive();
    run_until(5, 40, "t3_done");
    v = '0; drive();
    check_eq("t3_id0", id_log[0], 0);
    check_eq("t3_id1", id_log[1], 1);
    check_eq("t3_id2", id_log[2], 2);
    check_eq("t3_id3", id_log[3], 3);
    check_eq("t3_id4", id_log[4], 0);

    // decrement saturates at strong-not-taken
    do_reset();
    mode = 3; v[1] = 1'b1; ix[1] = 3'd5; oc[1] = 1'b0; drive();
    run_until(2, 30, "t4_done");
    v = '0; drive();
    check_eq("t4_pred0", pred_log[0], 0);
    check_eq("t4_match0", match_log[0], 1);
    check_eq("t4_pred1", pred_log[1], 0);
    check_eq("t4_match1", match_log[1], 1);

    // reset during RD aborts the transaction
    do_reset();
    mode = 4; v[2] = 1'b1; ix[2] = 3'd4; oc[2] = 1'b1; drive();
    for (int n = 0; n < 6 && m_phase != 1; n++) cycle();
    reset = 1'b1;
    v = '0; drive();
    @(negedge clk);
    check_eq("t5_rsp_valid_in_rst", bus.rsp_valid, 0);
    check_eq("t5_busy_in_rst", busy, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    m_reset();
    repeat (3) cycle();
    check_eq("t5_no_rsp", pred_log.size(), 0);
    v[2] = 1'b1; ix[2] = 3'd4; oc[2] = 1'b1; drive();
    run_until(1, 20, "t5_done");
    check_eq("t5_pred_after_rst", pred_log[0], 0);
    check_eq("t5_id_after_rst", id_log[0], 2);

    // randomized traffic with stat_clr
    do_reset();
    mode = 0;
    repeat (1500) cycle();
    mode = 4;
    repeat (6) cycle();

    // stat_clr coincident with a response
    v[0] = 1'b1; ix[0] = 3'd0; oc[0] = 1'b1; drive();
    for (int n = 0; n < 10 && m_phase != 2; n++) cycle();
    stat_clr = 1'b1;
    cycle();
    check_eq("t6_total_after_clr", total_cnt, 0);
    check_eq("t6_match_after_clr", match_cnt, 0);
    repeat (2) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
